// File: rtl/lane_packet_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_REQ beat streams into one registered output.
// Optional LANE_ARB_PKT_STATS_EN adds pkt_count, a wrapping count of accepted last beats.
module lane_packet_arbiter #(
  parameter int unsigned NUM_REQ    = 8,
  parameter int unsigned BLOCK_SIZE = 128
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               in_valid,
  output logic [NUM_REQ-1:0]               in_ready,
  input  logic [NUM_REQ*8*BLOCK_SIZE-1:0]  in_data,
  input  logic [NUM_REQ*4-1:0]             in_num,
  input  logic [NUM_REQ-1:0]               in_last,
  input  logic                             out_ready,
  output logic [8*BLOCK_SIZE-1:0]          out_data,
  output logic [31:0]                      out_num,
  output logic                             out_valid,
  output logic                             out_last,
  output logic [2:0]                       out_grant
`ifdef LANE_ARB_PKT_STATS_EN
  ,
  output logic [31:0]                      pkt_count
`endif
);

  localparam int unsigned DATA_W = 8 * BLOCK_SIZE;
  localparam int unsigned GW     = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant_idx, grant_nxt;
  logic [GW-1:0]   rr_ptr, rr_nxt;
  logic [GW-1:0]   sel_idx, cand;
  logic            sel_found;
  logic            accept;
  logic [DATA_W-1:0] beat_data;
  logic [3:0]      beat_num_raw, beat_num;
  logic [3:0]      num_q;

  // NUM_REQ is a power of two, so the GW-bit add wraps modulo NUM_REQ.
  always_comb begin
    sel_idx   = rr_ptr;
    sel_found = 1'b0;
    cand      = rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr + GW'(i);
      if (!sel_found && in_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    beat_data    = in_data[int'(grant_idx) * DATA_W +: DATA_W];
    beat_num_raw = in_num[int'(grant_idx) * 4 +: 4];
    beat_num     = (beat_num_raw > 4'd8) ? 4'd8 : beat_num_raw;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    rr_nxt    = rr_ptr;
    in_ready  = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_nxt = sel_idx;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        in_ready[grant_idx] = !out_valid || out_ready;
        accept = in_valid[grant_idx] && (!out_valid || out_ready);
        if (accept && in_last[grant_idx]) begin
          rr_nxt    = GW'(grant_idx + 1'b1);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      rr_ptr    <= rr_nxt;
    end
  end

  // A new acceptance overwrites a beat being drained in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      num_q     <= '0;
      out_grant <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_last  <= in_last[grant_idx];
      out_data  <= beat_data;
      num_q     <= beat_num;
      out_grant <= 3'(grant_idx);
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  assign out_num = {28'd0, num_q};

`ifdef LANE_ARB_PKT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else if (accept && in_last[grant_idx]) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lane_packet_arbiter.sv
// Directed bench for lane_packet_arbiter: one task per scenario, inline checks.
module tb_lane_packet_arbiter;
  localparam int NR = 8;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     in_valid;
  logic [NR-1:0]     in_ready;
  logic [NR*DW-1:0]  in_data;
  logic [NR*4-1:0]   in_num;
  logic [NR-1:0]     in_last;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [31:0]       out_num;
  logic              out_valid;
  logic              out_last;
  logic [2:0]        out_grant;
`ifdef LANE_ARB_PKT_STATS_EN
  logic [31:0]       pkt_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lane_packet_arbiter #(.NUM_REQ(NR), .BLOCK_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_num(in_num), .in_last(in_last), .out_ready(out_ready),
    .out_data(out_data), .out_num(out_num), .out_valid(out_valid),
    .out_last(out_last), .out_grant(out_grant)
`ifdef LANE_ARB_PKT_STATS_EN
    , .pkt_count(pkt_count)
`endif
  );

  function automatic logic [63:0] mk(int r, int k);
    return 64'hD0D0_0000_0000_0000 | 64'(r << 8) | 64'(k);
  endfunction

  task automatic put(int r, int k, logic [3:0] n, logic l);
    in_valid[r]           = 1'b1;
    in_data[r*DW +: DW]   = mk(r, k);
    in_num[r*4 +: 4]      = n;
    in_last[r]            = l;
  endtask

  task automatic do_reset;
    in_valid  = '0;
    in_last   = '0;
    in_num    = '0;
    in_data   = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    in_valid  = '0;
    in_last   = '0;
    in_num    = '0;
    in_data   = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    put(3, 0, 4'd8, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_num !== 32'd0 ||
        out_grant !== 3'd0 || out_data !== 64'd0)
      begin bad++; $display("FAIL reset_outputs: got v=%0b l=%0b n=%0d g=%0d d=%h want all 0",
                            out_valid, out_last, out_num, out_grant, out_data); end
    total++;
    if (in_ready !== 8'h00)
      begin bad++; $display("FAIL reset_in_ready: got %h want 00", in_ready); end
  endtask

  task automatic test_single_packet;
    logic [3:0] nums [4];
    nums = '{4'd8, 4'd8, 4'd8, 4'd5};
    do_reset;
    put(3, 0, nums[0], 1'b0);
    @(negedge clk);
    total++;
    if (in_ready !== 8'h08)
      begin bad++; $display("FAIL single_grant_ready: got %h want 08", in_ready); end
    total++;
    if (out_valid !== 1'b0)
      begin bad++; $display("FAIL single_latency: got out_valid=%0b want 0", out_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_grant !== 3'd3 || out_num !== 32'(nums[k]) ||
          out_data !== mk(3, k) || out_last !== (k == 3))
        begin bad++; $display("FAIL single_beat%0d: got v=%0b g=%0d n=%0d d=%h l=%0b want v=1 g=3 n=%0d d=%h l=%0b",
                              k, out_valid, out_grant, out_num, out_data, out_last, nums[k], mk(3, k), k == 3); end
      if (k < 3) put(3, k + 1, nums[k+1], (k + 1) == 3);
      else in_valid = '0;
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0)
      begin bad++; $display("FAIL single_drain: got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_round_robin;
    int got[$];
    int exp_g [4];
    exp_g = '{0, 5, 0, 5};
    do_reset;
    put(0, 0, 4'd1, 1'b1);
    put(5, 0, 4'd1, 1'b1);
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      @(negedge clk);
      if (out_valid) got.push_back(int'(out_grant));
    end
    in_valid = '0;
    total++;
    if (got.size() != 4)
      begin bad++; $display("FAIL rr_count: got %0d grants want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] != exp_g[i])
        begin bad++; $display("FAIL rr_order%0d: got %0d want %0d", i, got[i], exp_g[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    do_reset;
    put(2, 0, 4'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== mk(2, 0) || out_num !== 32'd1)
      begin bad++; $display("FAIL stall_first: got v=%0b d=%h n=%0d want v=1 d=%h n=1",
                            out_valid, out_data, out_num, mk(2, 0)); end
    put(2, 1, 4'd2, 1'b0);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== mk(2, 0) || out_num !== 32'd1 || in_ready !== 8'h00)
        begin bad++; $display("FAIL stall_hold%0d: got v=%0b d=%h n=%0d rdy=%h want v=1 d=%h n=1 rdy=00",
                              s, out_valid, out_data, out_num, in_ready, mk(2, 0)); end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 8'h04)
      begin bad++; $display("FAIL stall_release_ready: got %h want 04", in_ready); end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== mk(2, k) || out_num !== 32'(k + 1) || out_last !== (k == 3))
        begin bad++; $display("FAIL stall_beat%0d: got v=%0b d=%h n=%0d l=%0b want v=1 d=%h n=%0d l=%0b",
                              k, out_valid, out_data, out_num, out_last, mk(2, k), k + 1, k == 3); end
      if (k < 3) put(2, k + 1, 4'(k + 2), (k + 1) == 3);
      else in_valid = '0;
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0)
      begin bad++; $display("FAIL stall_no_dup: got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_num_clamp;
    do_reset;
    put(1, 0, 4'd12, 1'b0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_num !== 32'd8 || out_last !== 1'b0)
      begin bad++; $display("FAIL clamp_12: got v=%0b n=%0d l=%0b want v=1 n=8 l=0",
                            out_valid, out_num, out_last); end
    put(1, 1, 4'd0, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_num !== 32'd0 || out_last !== 1'b1 || out_data !== mk(1, 1))
      begin bad++; $display("FAIL clamp_zero_last: got v=%0b n=%0d l=%0b d=%h want v=1 n=0 l=1 d=%h",
                            out_valid, out_num, out_last, out_data, mk(1, 1)); end
    in_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_packet;
    do_reset;
    put(1, 0, 4'd1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_grant !== 3'd1)
      begin bad++; $display("FAIL rst_pre_grant: got v=%0b g=%0d want v=1 g=1", out_valid, out_grant); end
    put(5, 0, 4'd8, 1'b0);
    @(negedge clk);
    total++;
    if (in_ready !== 8'h20)
      begin bad++; $display("FAIL rst_rr_from2: got rdy=%h want 20", in_ready); end
    @(negedge clk);
    put(5, 1, 4'd8, 1'b0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_grant !== 3'd5 || out_data !== mk(5, 1))
      begin bad++; $display("FAIL rst_beat2: got v=%0b g=%0d d=%h want v=1 g=5 d=%h",
                            out_valid, out_grant, out_data, mk(5, 1)); end
    rst_n = 1'b0;
    put(5, 2, 4'd8, 1'b1);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_num !== 32'd0 || out_grant !== 3'd0 ||
        out_data !== 64'd0 || in_ready !== 8'h00)
      begin bad++; $display("FAIL rst_async_clear: got v=%0b l=%0b n=%0d g=%0d d=%h rdy=%h want all 0",
                            out_valid, out_last, out_num, out_grant, out_data, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 8'h02)
      begin bad++; $display("FAIL rst_restart_ready: got %h want 02", in_ready); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_grant !== 3'd1 || out_data !== mk(1, 0))
      begin bad++; $display("FAIL rst_restart_grant: got v=%0b g=%0d d=%h want v=1 g=1 d=%h",
                            out_valid, out_grant, out_data, mk(1, 0)); end
    in_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_packet_stats;
    int n;
    n = 0;
    do_reset;
    put(1, 0, 4'd2, 1'b1);
    put(7, 0, 4'd2, 1'b1);
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (out_grant !== ((n % 2 == 0) ? 3'd1 : 3'd7) || out_last !== 1'b1)
          begin bad++; $display("FAIL stats_pkt%0d: got g=%0d l=%0b want g=%0d l=1",
                                n, out_grant, out_last, (n % 2 == 0) ? 1 : 7); end
        n++;
        if (n == 10) in_valid = '0;
      end
    end
    in_valid = '0;
    total++;
    if (n != 10)
      begin bad++; $display("FAIL stats_pkt_total: got %0d packets want 10", n); end
    @(negedge clk);
`ifdef LANE_ARB_PKT_STATS_EN
    total++;
    if (pkt_count !== 32'd10)
      begin bad++; $display("FAIL stats_count: got %0d want 10", pkt_count); end
`endif
  endtask

  initial begin
    test_reset;
    test_single_packet;
    test_round_robin;
    test_backpressure;
    test_num_clamp;
    test_reset_mid_packet;
    test_packet_stats;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
